multi_grant_rr_select: RTL and testbench
========================================

// Module: multi_grant_rr_select
// PURPOSE
//  Parametrised N-of-WIDTH request selector for issue-queue wakeup/select and free-list allocation.
//  Each enabled cycle, picks up to GRANTS requesters from req_i in priority order.
//  Priority is either fixed (bit 0 highest) or round-robin from a rotating pointer.
//  Grants are registered (1-cycle latency), so the block sits between the request
//  vector and issue/dispatch pipeline stages.
// PARAMETERS
//  WIDTH     32  number of requesters (>=2)
//  GRANTS    2   max grants per cycle (1..WIDTH)
//  RR_MODE   1   1 = round-robin priority from ptr; 0 = fixed priority, bit 0 highest
//  IDX_W     $clog2(WIDTH)  index width (derived, not overridable)
// PORTS
//  clk            in   1               clock
//  reset          in   1               synchronous, active-high reset
//  req_i          in   WIDTH           request vector
//  enable_i       in   1               1 = perform selection this cycle; 0 = stall/hold
//  flush_i        in   1               discard selection; grant_valid_o = 0 next cycle
//  grant_vec_o    out  GRANTS*WIDTH    per-grant one-hot vector; slice g = [g*WIDTH +: WIDTH]
//  grant_idx_o    out  GRANTS*IDX_W    per-grant binary index of the granted bit
//  grant_valid_o  out  GRANTS          per-grant valid
//  grant_all_o    out  WIDTH           OR of all grant_vec_o slices
//  ptr_o          out  IDX_W           current highest-priority position
// BEHAVIOUR
//  - Clock is clk; reset is synchronous and active-high (name: reset).
//  - Reset: all outputs 0; ptr = 0.
//  - Scan order: ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1 (mod WIDTH).
//    With RR_MODE=0, ptr is held at 0, giving plain lowest-index-first order.
//  - Grant g is the (g+1)-th set bit of req_i in scan order.
//  - If fewer than g+1 bits are set:
//    grant_valid_o[g] = 0, its vec and idx slices are 0.
//    Valid grants are always packed low: valid bit g implies valid bits 0..g-1.
//  - Grants are disjoint one-hot; grant_all_o = bitwise OR of the valid slices.
//  - Update on clk edge with enable_i=1 and flush_i=0:
//    outputs <= selection computed from the current req_i and ptr.
//    If RR_MODE=1 and at least one grant is valid: ptr <= (idx of last valid grant + 1) mod WIDTH.
//    Otherwise ptr is unchanged.
//  - enable_i=0 and flush_i=0: all outputs and ptr hold their values.
//    req_i is ignored that cycle.
//  - flush_i=1 (regardless of enable_i): grant_valid_o, grant_vec_o, grant_idx_o and grant_all_o <= 0.
//    ptr unchanged. Flush has priority over enable.
//  - Reset has priority over flush and enable; reset mid-stream discards any in-flight selection.
//  - Wrap-around: requests below ptr are still granted once the scan wraps;
//    ptr = WIDTH-1 followed by a grant at WIDTH-1 gives ptr = 0.
//  - req_i all zero with enable_i=1: all valids 0 next cycle; ptr unchanged.
//  - No combinational path from any input to any output.
//  - Implementation: rotate req_i by ptr, run a GRANTS-deep cascaded first-one mask,
//    then un-rotate the results; no behavioural loops over time.
// TESTING (WIDTH=8, GRANTS=2, RR_MODE=1 unless noted)
//  1. reset=1 for 2 cycles, then req_i=8'h00, enable_i=1
//     -> all outputs 0, ptr_o=0.
//  2. ptr=0, req_i=8'b1011_0100, enable_i=1
//     -> next cycle: idx0=2, idx1=4, valid=2'b11, grant_all_o=8'h14, ptr_o=5.
//  3. ptr=5, req_i=8'b0000_0101
//     -> idx0=0, idx1=2 (wrap), valid=2'b11, ptr_o=3.
//  4. ptr=3, req_i=8'h80
//     -> idx0=7, valid=2'b01, slice 1 all zero, ptr_o=0.
//  5. Stall and flush:
//     a. enable_i=0 with req_i changing -> outputs and ptr_o hold.
//     b. flush_i=1 with enable_i=1 -> valid=2'b00, ptr_o unchanged.
//     c. reset asserted in the same cycle as flush -> all outputs 0, ptr_o=0.
//  6. RR_MODE=0, req_i=8'hFF held for 4 cycles -> every cycle idx0=0, idx1=1, ptr_o=0.
//     Random-request regression against a reference model: grants disjoint and packed,
//     and no starvation in RR mode (every held request is granted within ceil(WIDTH/GRANTS) cycles).

Source files
------------

// File: rtl/multi_grant_rr_select_if.sv
// Request/grant bundle for the multi-grant selector.
// The master drives requests and the slave returns registered grants.
interface multi_grant_rr_select_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GRANTS = 2
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0]        req_i;
    logic                    enable_i;
    logic                    flush_i;
    logic [GRANTS*WIDTH-1:0] grant_vec_o;
    logic [GRANTS*IDX_W-1:0] grant_idx_o;
    logic [GRANTS-1:0]       grant_valid_o;
    logic [WIDTH-1:0]        grant_all_o;
    logic [IDX_W-1:0]        ptr_o;

    modport master (
        output req_i, enable_i, flush_i,
        input  grant_vec_o, grant_idx_o, grant_valid_o, grant_all_o, ptr_o
    );

    modport slave (
        input  req_i, enable_i, flush_i,
        output grant_vec_o, grant_idx_o, grant_valid_o, grant_all_o, ptr_o
    );
endinterface

// File: rtl/multi_grant_rr_select.sv
// N-of-WIDTH request selector with fixed or round-robin priority.
// Each enabled cycle it registers up to GRANTS disjoint one-hot grants.
module multi_grant_rr_select #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned GRANTS  = 2,
    parameter int unsigned RR_MODE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    multi_grant_rr_select_if.slave        sel
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [GRANTS*WIDTH-1:0] vec_q,   vec_d;
    logic [GRANTS*IDX_W-1:0] idx_q,   idx_d;
    logic [GRANTS-1:0]       valid_q, valid_d;
    logic [WIDTH-1:0]        all_q,   all_d;
    logic [IDX_W-1:0]        ptr_q,   ptr_d;

    logic [2*WIDTH-1:0]      rot_dbl;
    logic [2*WIDTH-1:0]      unrot_dbl;
    logic [WIDTH-1:0]        remaining;
    logic [WIDTH-1:0]        pick;
    logic [WIDTH-1:0]        slice;
    logic [IDX_W-1:0]        enc;
    logic [IDX_W-1:0]        last_idx;

    // Rotate so ptr lands at bit 0, peel off GRANTS lowest set bits, rotate each back.
    always_comb begin
        rot_dbl   = {sel.req_i, sel.req_i} >> ptr_q;
        remaining = rot_dbl[WIDTH-1:0];
        pick      = '0;
        unrot_dbl = '0;
        slice     = '0;
        enc       = '0;
        last_idx  = '0;
        vec_d     = '0;
        idx_d     = '0;
        valid_d   = '0;
        all_d     = '0;
        for (int unsigned g = 0; g < GRANTS; g++) begin
            pick      = remaining & (~remaining + WIDTH'(1));
            remaining = remaining & ~pick;
            unrot_dbl = {pick, pick} << ptr_q;
            slice     = unrot_dbl[2*WIDTH-1:WIDTH];
            enc       = '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (slice[i]) enc = enc | IDX_W'(i);
            end
            vec_d[g*WIDTH +: WIDTH] = slice;
            idx_d[g*IDX_W +: IDX_W] = enc;
            valid_d[g]              = |slice;
            all_d                   = all_d | slice;
            if (|slice) last_idx = enc;
        end

        ptr_d = ptr_q;
        if ((RR_MODE != 0) && (|valid_d)) begin
            ptr_d = (last_idx == IDX_W'(WIDTH - 1)) ? '0 : last_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_q   <= '0;
            idx_q   <= '0;
            valid_q <= '0;
            all_q   <= '0;
            ptr_q   <= '0;
        end else if (sel.flush_i) begin
            vec_q   <= '0;
            idx_q   <= '0;
            valid_q <= '0;
            all_q   <= '0;
        end else if (sel.enable_i) begin
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            all_q   <= all_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel.grant_vec_o   = vec_q;
    assign sel.grant_idx_o   = idx_q;
    assign sel.grant_valid_o = valid_q;
    assign sel.grant_all_o   = all_q;
    assign sel.ptr_o         = ptr_q;
endmodule

// File: tb/tb_multi_grant_rr_select.sv
// Directed and model-based checks for multi_grant_rr_select (WIDTH=8, GRANTS=2).
// Two instances share the clock: one round-robin, one fixed priority.
module tb_multi_grant_rr_select;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multi_grant_rr_select_if #(.WIDTH(8), .GRANTS(2)) bus_rr ();
    multi_grant_rr_select_if #(.WIDTH(8), .GRANTS(2)) bus_fx ();

    multi_grant_rr_select #(.WIDTH(8), .GRANTS(2), .RR_MODE(1)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .sel   (bus_rr.slave)
    );

    multi_grant_rr_select #(.WIDTH(8), .GRANTS(2), .RR_MODE(0)) dut_fx (
        .clk   (clk),
        .reset (reset),
        .sel   (bus_fx.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rr(input string tag, input logic [15:0] vec, input logic [5:0] idx,
                            input logic [1:0] valid, input logic [7:0] all, input logic [2:0] ptr);
        check({tag, ".vec"},   32'(bus_rr.grant_vec_o),   32'(vec));
        check({tag, ".idx"},   32'(bus_rr.grant_idx_o),   32'(idx));
        check({tag, ".valid"}, 32'(bus_rr.grant_valid_o), 32'(valid));
        check({tag, ".all"},   32'(bus_rr.grant_all_o),   32'(all));
        check({tag, ".ptr"},   32'(bus_rr.ptr_o),         32'(ptr));
    endtask

    // Reference: walk the scan order from ptr and take the first two set bits.
    task automatic model(input logic [7:0] req, input logic [2:0] ptr,
                         output logic [15:0] vec, output logic [5:0] idx,
                         output logic [1:0] valid, output logic [7:0] all,
                         output logic [2:0] nptr);
        int cnt = 0;
        int pos;
        vec = '0; idx = '0; valid = '0; all = '0; nptr = ptr;
        for (int k = 0; k < 8; k++) begin
            pos = (int'(ptr) + k) % 8;
            if (req[pos] && cnt < 2) begin
                vec[cnt*8 + pos] = 1'b1;
                idx[cnt*3 +: 3]  = 3'(pos);
                valid[cnt]       = 1'b1;
                all[pos]         = 1'b1;
                nptr             = 3'((pos + 1) % 8);
                cnt++;
            end
        end
    endtask

    initial begin
        logic [15:0] e_vec;
        logic [5:0]  e_idx;
        logic [1:0]  e_valid;
        logic [7:0]  e_all;
        logic [2:0]  e_ptr, m_ptr, n_ptr;
        logic [7:0]  req;
        logic        en, fl;
        logic [7:0]  seen;

        reset = 1'b1;
        bus_rr.req_i = '0; bus_rr.enable_i = 1'b0; bus_rr.flush_i = 1'b0;
        bus_fx.req_i = '0; bus_fx.enable_i = 1'b0; bus_fx.flush_i = 1'b0;
        tick(); tick();
        check_rr("reset", 16'h0, 6'h0, 2'b00, 8'h00, 3'd0);

        reset = 1'b0;
        bus_rr.req_i = 8'h00; bus_rr.enable_i = 1'b1;
        tick();
        check_rr("empty", 16'h0, 6'h0, 2'b00, 8'h00, 3'd0);

        bus_rr.req_i = 8'b1011_0100;
        tick();
        check_rr("two", 16'h1004, 6'b100_010, 2'b11, 8'h14, 3'd5);

        bus_rr.req_i = 8'b0000_0101;
        tick();
        check_rr("wrap", 16'h0401, 6'b010_000, 2'b11, 8'h05, 3'd3);

        bus_rr.req_i = 8'h80;
        tick();
        check_rr("single", 16'h0080, 6'b000_111, 2'b01, 8'h80, 3'd0);

        bus_rr.enable_i = 1'b0; bus_rr.req_i = 8'hFF;
        tick();
        bus_rr.req_i = 8'h3C;
        tick();
        check_rr("stall", 16'h0080, 6'b000_111, 2'b01, 8'h80, 3'd0);

        bus_rr.enable_i = 1'b1; bus_rr.req_i = 8'h0C;
        tick();
        check_rr("pre_flush", 16'h0804, 6'b011_010, 2'b11, 8'h0C, 3'd4);

        bus_rr.flush_i = 1'b1; bus_rr.req_i = 8'hFF;
        tick();
        check_rr("flush", 16'h0, 6'h0, 2'b00, 8'h00, 3'd4);

        bus_rr.flush_i = 1'b0; bus_rr.req_i = 8'h01;
        tick();
        check_rr("pre_rst", 16'h0001, 6'b000_000, 2'b01, 8'h01, 3'd1);

        reset = 1'b1; bus_rr.flush_i = 1'b1; bus_rr.req_i = 8'hFF;
        tick();
        check_rr("rst_flush", 16'h0, 6'h0, 2'b00, 8'h00, 3'd0);

        reset = 1'b0; bus_rr.flush_i = 1'b0; bus_rr.req_i = 8'h40;
        tick();
        check_rr("to_ptr7", 16'h0040, 6'b000_110, 2'b01, 8'h40, 3'd7);

        bus_rr.req_i = 8'h00;
        tick();
        check_rr("empty_hold", 16'h0, 6'h0, 2'b00, 8'h00, 3'd7);

        bus_rr.req_i = 8'h80;
        tick();
        check_rr("ptr_wrap", 16'h0080, 6'b000_111, 2'b01, 8'h80, 3'd0);

        // All requesters held: every one must see a grant within 4 cycles.
        bus_rr.req_i = 8'hFF;
        seen = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen = seen | bus_rr.grant_all_o;
        end
        check("no_starve", 32'(seen), 32'hFF);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_ptr = '0;
        for (int c = 0; c < 200; c++) begin
            req = 8'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 9) == 0);
            bus_rr.req_i = req; bus_rr.enable_i = en; bus_rr.flush_i = fl;
            if (fl) begin
                e_vec = '0; e_idx = '0; e_valid = '0; e_all = '0;
            end else if (en) begin
                model(req, m_ptr, e_vec, e_idx, e_valid, e_all, n_ptr);
                m_ptr = n_ptr;
            end
            tick();
            if (fl || en) begin
                check_rr($sformatf("rand%0d", c), e_vec, e_idx, e_valid, e_all, m_ptr);
            end else begin
                check(  $sformatf("rand%0d.ptr", c), 32'(bus_rr.ptr_o), 32'(m_ptr));
            end
        end

        bus_rr.enable_i = 1'b0; bus_rr.flush_i = 1'b0;
        bus_fx.req_i = 8'hFF; bus_fx.enable_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("fixed%0d.idx", c),   32'(bus_fx.grant_idx_o),   32'(6'b001_000));
            check($sformatf("fixed%0d.valid", c), 32'(bus_fx.grant_valid_o), 32'(2'b11));
            check($sformatf("fixed%0d.ptr", c),   32'(bus_fx.ptr_o),         32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
